// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the FSM state encoding, the owner encoding and the latency counter width.
package mem_arb_pkg;

    // Latency counter width; bounds MEM_LAT to 1..15.
    localparam int LAT_W = 4;

    // FSM state encoding.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Owner encoding, also the value driven on the 'owner' output.
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter that times the memory slot of the arbiter.
// Latency: count visible one cycle after load; last_o decoded from the register.
// Backpressure: none; load and decrement are unconditional when requested.
//
// Ports:
//   clk, rst     clock and asynchronous active-low reset
//   load_i       load load_val_i into the counter (takes precedence over dec_i)
//   load_val_i   value to load
//   dec_i        decrement by one; holds at zero
//   last_o       high while the count equals 1 (final wait cycle)
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency synchronous memory between the cpu port and the loader/debug port.
// Latency: req sampled in IDLE at cycle t -> memEn at t+1, done at t+2+MEM_LAT; slot is MEM_LAT+3.
// Backpressure: requesters hold req (with stable adr/we/wData) until served; no abort once granted.
//
// Configuration macro MEM_ARB_RR_EN:
//   defined   - round-robin: on a simultaneous request the port that did not own the last
//               completed transaction wins.
//   undefined - fixed priority: cpu always wins a conflict; ldr only served with cpuReq low.
//
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   cpuReq/cpuWe/cpuAdr/cpuWData     cpu request group (inputs)
//   cpuRData, cpuDone                cpu read data register and one-cycle completion pulse
//   ldrReq/ldrWe/ldrAdr/ldrWData     loader request group (inputs)
//   ldrRData, ldrDone                loader read data register and completion pulse
//   memEn, memWe, memAdr, memWData   memory strobe (one cycle per access) and latched request
//   memRData                         memory read data, valid MEM_LAT cycles after memEn
//   busy                             high in every state except IDLE
//   owner                            0 = cpu, 1 = ldr; current or last grant
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuAdr,
    input  logic [DW-1:0] cpuWData,
    output logic [DW-1:0] cpuRData,
    output logic          cpuDone,

    input  logic          ldrReq,
    input  logic          ldrWe,
    input  logic [AW-1:0] ldrAdr,
    input  logic [DW-1:0] ldrWData,
    output logic [DW-1:0] ldrRData,
    output logic          ldrDone,

    output logic          memEn,
    output logic          memWe,
    output logic [AW-1:0] memAdr,
    output logic [DW-1:0] memWData,
    input  logic [DW-1:0] memRData,

    output logic          busy,
    output logic          owner
);

    // The 4-bit counter cannot represent a latency outside 1..15.
    generate
        if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT must be in the range 1..15");
        end
    endgenerate

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);

    logic [1:0]    state_q,      state_d;
    logic          owner_q,      owner_d;
    logic          last_owner_q, last_owner_d;
    logic          we_q,         we_d;
    logic [AW-1:0] adr_q,        adr_d;
    logic [DW-1:0] wdat_q,       wdat_d;
    logic [DW-1:0] cpu_rdat_q,   cpu_rdat_d;
    logic [DW-1:0] ldr_rdat_q,   ldr_rdat_d;

    logic          grant;
    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_last;

    // Arbitration decision, only consumed in IDLE with at least one request present.
`ifdef MEM_ARB_RR_EN
    always_comb begin
        if (cpuReq && ldrReq) begin
            grant = ~last_owner_q;
        end else if (ldrReq) begin
            grant = OWNER_LDR;
        end else begin
            grant = OWNER_CPU;
        end
    end
`else
    always_comb begin
        grant = cpuReq ? OWNER_CPU : OWNER_LDR;
    end
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        adr_d        = adr_q;
        wdat_d       = wdat_q;
        cpu_rdat_d   = cpu_rdat_q;
        ldr_rdat_d   = ldr_rdat_q;

        case (state_q)
            IDLE: begin
                if (cpuReq || ldrReq) begin
                    owner_d = grant;
                    if (grant == OWNER_LDR) begin
                        we_d   = ldrWe;
                        adr_d  = ldrAdr;
                        wdat_d = ldrWData;
                    end else begin
                        we_d   = cpuWe;
                        adr_d  = cpuAdr;
                        wdat_d = cpuWData;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = WAIT;
            end
            WAIT: begin
                // The counter reads 1 exactly MEM_LAT cycles after the strobe, which is
                // when the memory presents the read data.
                if (cnt_last) begin
                    if (!we_q) begin
                        if (owner_q == OWNER_LDR) begin
                            ldr_rdat_d = memRData;
                        end else begin
                            cpu_rdat_d = memRData;
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cnt_load = (state_q == ACCESS);
    assign cnt_dec  = (state_q == WAIT);

    mem_arb_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_CPU;
            // Pretend the loader went last so the first conflict goes to the cpu.
            last_owner_q <= OWNER_LDR;
            we_q         <= 1'b0;
            adr_q        <= '0;
            wdat_q       <= '0;
            cpu_rdat_q   <= '0;
            ldr_rdat_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            wdat_q       <= wdat_d;
            cpu_rdat_q   <= cpu_rdat_d;
            ldr_rdat_q   <= ldr_rdat_d;
        end
    end

    // Outputs are decoded from registered state only, so they are glitch-free and all
    // zero in reset.
    assign memEn    = (state_q == ACCESS);
    assign memWe    = memEn && we_q;
    assign memAdr   = adr_q;
    assign memWData = wdat_q;

    assign cpuDone  = (state_q == DONE) && (owner_q == OWNER_CPU);
    assign ldrDone  = (state_q == DONE) && (owner_q == OWNER_LDR);
    assign cpuRData = cpu_rdat_q;
    assign ldrRData = ldr_rdat_q;

    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int NI = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 15);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    [NI];
    logic        cpuReq   [NI];
    logic        cpuWe    [NI];
    logic [31:0] cpuAdr   [NI];
    logic [31:0] cpuWData [NI];
    logic [31:0] cpuRData [NI];
    logic        cpuDone  [NI];
    logic        ldrReq   [NI];
    logic        ldrWe    [NI];
    logic [31:0] ldrAdr   [NI];
    logic [31:0] ldrWData [NI];
    logic [31:0] ldrRData [NI];
    logic        ldrDone  [NI];
    logic        memEn    [NI];
    logic        memWe    [NI];
    logic [31:0] memAdr   [NI];
    logic [31:0] memWData [NI];
    logic [31:0] memRData [NI];
    logic        busy     [NI];
    logic        owner    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(lat_of(g))) u_dut (
            .clk      (clk),
            .rst      (rst_n[g]),
            .cpuReq   (cpuReq[g]),
            .cpuWe    (cpuWe[g]),
            .cpuAdr   (cpuAdr[g]),
            .cpuWData (cpuWData[g]),
            .cpuRData (cpuRData[g]),
            .cpuDone  (cpuDone[g]),
            .ldrReq   (ldrReq[g]),
            .ldrWe    (ldrWe[g]),
            .ldrAdr   (ldrAdr[g]),
            .ldrWData (ldrWData[g]),
            .ldrRData (ldrRData[g]),
            .ldrDone  (ldrDone[g]),
            .memEn    (memEn[g]),
            .memWe    (memWe[g]),
            .memAdr   (memAdr[g]),
            .memWData (memWData[g]),
            .memRData (memRData[g]),
            .busy     (busy[g]),
            .owner    (owner[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents seen by every instance.
    function automatic logic [31:0] mem_rd(input logic [31:0] adr);
        logic [15:0] lo;
        lo = adr[15:0];
        if (adr == 32'h10) return 32'hDEADBEEF;
        return {lo ^ 16'h5A5A, ~lo};
    endfunction

    typedef struct {
        int          k;
        logic        port;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          en_exp;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor state
    int          rd_left    [NI];
    logic        rd_armed   [NI];
    logic [31:0] rd_dat     [NI];
    logic [31:0] exp_cpu_rd [NI];
    logic [31:0] exp_ldr_rd [NI];
    logic        strobed = 1'b0;
    int          en_cyc = 0;
    int          done_cnt = 0;
    int          last_done_cyc = 0;

    // Memory model plus scoreboard, evaluated on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                memRData[k] = 32'hBAD00000 ^ 32'(cyc);
                if (rst_n[k] !== 1'b1) begin
                    rd_armed[k]   = 1'b0;
                    rd_left[k]    = 0;
                    exp_cpu_rd[k] = '0;
                    exp_ldr_rd[k] = '0;
                    if (sb.size() > 0 && sb[0].k == k) begin
                        sb.delete();
                        strobed = 1'b0;
                    end
                end else begin
                    if (rd_armed[k]) begin
                        rd_left[k]--;
                        if (rd_left[k] == 0) begin
                            memRData[k] = rd_dat[k];
                            rd_armed[k] = 1'b0;
                        end
                    end
                    check($sformatf("k%0d_memwe_qual", k), 64'(memWe[k] & ~memEn[k]), 64'd0);
                    if (memEn[k]) begin
                        rd_armed[k] = 1'b1;
                        rd_left[k]  = lat_of(k);
                        rd_dat[k]   = mem_rd(memAdr[k]);
                        if (sb.size() == 0 || sb[0].k != k) begin
                            check($sformatf("k%0d_en_unexpected", k), 64'd1, 64'd0);
                        end else begin
                            check($sformatf("k%0d_en_twice", k), 64'(strobed), 64'd0);
                            check($sformatf("k%0d_en_cyc", k), 64'(cyc), 64'(sb[0].en_exp));
                            check($sformatf("k%0d_en_owner", k), 64'(owner[k]), 64'(sb[0].port));
                            check($sformatf("k%0d_en_we", k), 64'(memWe[k]), 64'(sb[0].we));
                            check($sformatf("k%0d_en_adr", k), 64'(memAdr[k]), 64'(sb[0].adr));
                            if (sb[0].we) begin
                                check($sformatf("k%0d_en_wdat", k), 64'(memWData[k]), 64'(sb[0].wdat));
                            end
                            strobed = 1'b1;
                            en_cyc  = cyc;
                        end
                    end
                    if (cpuDone[k] || ldrDone[k]) begin
                        check($sformatf("k%0d_done_both", k), 64'(cpuDone[k] & ldrDone[k]), 64'd0);
                        if (sb.size() == 0 || sb[0].k != k) begin
                            check($sformatf("k%0d_done_unexpected", k), 64'd1, 64'd0);
                        end else begin
                            e = sb.pop_front();
                            check($sformatf("k%0d_done_port", k), 64'(ldrDone[k]), 64'(e.port));
                            check($sformatf("k%0d_done_strobed", k), 64'(strobed), 64'd1);
                            check($sformatf("k%0d_done_cyc", k), 64'(cyc), 64'(en_cyc + lat_of(k) + 1));
                            if (!e.we) begin
                                if (e.port) exp_ldr_rd[k] = e.rdat;
                                else        exp_cpu_rd[k] = e.rdat;
                            end
                            check($sformatf("k%0d_cpu_rdata", k), 64'(cpuRData[k]), 64'(exp_cpu_rd[k]));
                            check($sformatf("k%0d_ldr_rdata", k), 64'(ldrRData[k]), 64'(exp_ldr_rd[k]));
                            strobed = 1'b0;
                        end
                        done_cnt++;
                        last_done_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input int k, input logic we, input logic [31:0] adr, input logic [31:0] wdat);
        cpuReq[k] = 1'b1; cpuWe[k] = we; cpuAdr[k] = adr; cpuWData[k] = wdat;
    endtask

    task automatic drive_ldr(input int k, input logic we, input logic [31:0] adr, input logic [31:0] wdat);
        ldrReq[k] = 1'b1; ldrWe[k] = we; ldrAdr[k] = adr; ldrWData[k] = wdat;
    endtask

    task automatic expect_txn(input int k, input logic port, input logic we,
                              input logic [31:0] adr, input logic [31:0] wdat, input int en_exp);
        exp_t e;
        e.k = k; e.port = port; e.we = we; e.adr = adr; e.wdat = wdat;
        e.rdat = we ? 32'h0 : mem_rd(adr);
        e.en_exp = en_exp;
        sb.push_back(e);
    endtask

    task automatic wait_dones(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt < target) check({tag, "_timeout"}, 64'(done_cnt), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base;
        int prev;
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b0;
            cpuReq[k] = 1'b0; cpuWe[k] = 1'b0; cpuAdr[k] = '0; cpuWData[k] = '0;
            ldrReq[k] = 1'b0; ldrWe[k] = 1'b0; ldrAdr[k] = '0; ldrWData[k] = '0;
        end
        repeat (3) tick();

        // Reset state
        for (int k = 0; k < NI; k++) begin
            check($sformatf("k%0d_rst_busy", k), 64'(busy[k]), 64'd0);
            check($sformatf("k%0d_rst_memen", k), 64'({memEn[k], memWe[k]}), 64'd0);
            check($sformatf("k%0d_rst_done", k), 64'({cpuDone[k], ldrDone[k]}), 64'd0);
            check($sformatf("k%0d_rst_owner", k), 64'(owner[k]), 64'd0);
            check($sformatf("k%0d_rst_rdata", k), {cpuRData[k], ldrRData[k]}, 64'd0);
            check($sformatf("k%0d_rst_memadr", k), {memAdr[k], memWData[k]}, 64'd0);
        end
        for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
        tick();

        // Single cpu read, MEM_LAT=1
        t = cyc;
        drive_cpu(0, 1'b0, 32'h10, 32'h0);
        expect_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, t + 1);
        tick();
        cpuReq[0] = 1'b0;
        wait_dones(1, 10, "t2");
        check("t2_done_cyc", 64'(last_done_cyc), 64'(t + 3));
        check("t2_cpu_rdata", 64'(cpuRData[0]), 64'h0DEADBEEF);
        check("t2_ldr_rdata", 64'(ldrRData[0]), 64'd0);

        // Loader write
        t = cyc;
        drive_ldr(0, 1'b1, 32'h20, 32'h12345678);
        expect_txn(0, 1'b1, 1'b1, 32'h20, 32'h12345678, t + 1);
        tick();
        ldrReq[0] = 1'b0;
        wait_dones(2, 10, "t3");
        check("t3_done_cyc", 64'(last_done_cyc), 64'(t + 2 + lat_of(0)));
        check("t3_cpu_rdata", 64'(cpuRData[0]), 64'h0DEADBEEF);
        check("t3_ldr_rdata", 64'(ldrRData[0]), 64'd0);

        // cpuReq dropped during WAIT
        t = cyc;
        drive_cpu(0, 1'b0, 32'h44, 32'h0);
        expect_txn(0, 1'b0, 1'b0, 32'h44, 32'h0, t + 1);
        tick();
        tick();
        cpuReq[0] = 1'b0;
        wait_dones(3, 10, "t5");
        check("t5_done_cyc", 64'(last_done_cyc), 64'(t + 3));
        check("t5_idle_busy", 64'(busy[0]), 64'd0);
        tick();
        check("t5_no_regrant", 64'({busy[0], memEn[0]}), 64'd0);

        // Simultaneous held requests, four transactions
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        tick();
        t = cyc;
        base = done_cnt;
        drive_cpu(0, 1'b0, 32'h100, 32'h0);
        drive_ldr(0, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            if (i % 2 == 0) expect_txn(0, 1'b0, 1'b0, 32'h100, 32'h0, t + 1 + i * (lat_of(0) + 3));
            else            expect_txn(0, 1'b1, 1'b0, 32'h200, 32'h0, t + 1 + i * (lat_of(0) + 3));
`else
            expect_txn(0, 1'b0, 1'b0, 32'h100, 32'h0, t + 1 + i * (lat_of(0) + 3));
`endif
        end
        wait_dones(base + 4, 40, "t4");
        cpuReq[0] = 1'b0;
        ldrReq[0] = 1'b0;
        tick();
        tick();
        check("t4_idle_after", 64'(busy[0]), 64'd0);

        // Reset while a MEM_LAT=3 read is waiting
        t = cyc;
        drive_cpu(1, 1'b0, 32'h30, 32'h0);
        expect_txn(1, 1'b0, 1'b0, 32'h30, 32'h0, t + 1);
        tick();
        cpuReq[1] = 1'b0;
        wait_dones(done_cnt + 1, 15, "t1a");
        check("t1_first_rdata", 64'(cpuRData[1]), 64'(mem_rd(32'h30)));
        t = cyc;
        drive_cpu(1, 1'b0, 32'h34, 32'h0);
        expect_txn(1, 1'b0, 1'b0, 32'h34, 32'h0, t + 1);
        tick();
        cpuReq[1] = 1'b0;
        tick();
        check("t1_inflight_busy", 64'(busy[1]), 64'd1);
        base = done_cnt;
        rst_n[1] = 1'b0;
        #1;
        check("t1_rst_busy", 64'(busy[1]), 64'd0);
        check("t1_rst_memen", 64'(memEn[1]), 64'd0);
        check("t1_rst_cpudone", 64'(cpuDone[1]), 64'd0);
        check("t1_rst_rdata", 64'(cpuRData[1]), 64'd0);
        tick();
        check("t1_rst_edge_busy", 64'(busy[1]), 64'd0);
        check("t1_rst_edge_rdata", 64'(cpuRData[1]), 64'd0);
        rst_n[1] = 1'b1;
        repeat (8) tick();
        check("t1_no_done", 64'(done_cnt), 64'(base));
        check("t1_idle", 64'(busy[1]), 64'd0);

        // Back-to-back cpu reads, MEM_LAT=15
        t = cyc;
        base = done_cnt;
        prev = 0;
        drive_cpu(2, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 3; i++) expect_txn(2, 1'b0, 1'b0, 32'h40, 32'h0, t + 1 + i * 18);
        for (int n = 0; n < 3; n++) begin
            wait_dones(base + n + 1, 25, "t6");
            check($sformatf("t6_bubble%0d", n), 64'(busy[2]), 64'd0);
            if (n > 0) check($sformatf("t6_spacing%0d", n), 64'(last_done_cyc - prev), 64'd18);
            prev = last_done_cyc;
            if (n == 2) begin
                cpuReq[2] = 1'b0;
            end else begin
                tick();
                check($sformatf("t6_rebusy%0d", n), 64'(busy[2]), 64'd1);
            end
        end

        repeat (4) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
